// File: rtl/ar_rx_pkg.sv
// rtl/ar_rx_pkg.sv - shared types, rate constants and pulse-width window for the ARINC-429 receiver
package ar_rx_pkg;

  typedef enum logic [1:0] {
    S_SKIP = 2'd0,
    S_GAP  = 2'd1,
    S_BITS = 2'd2
  } state_e;

  localparam int F_CE_DEF = 10_000_000;
  localparam int REC_W    = 33;
  localparam int TMR_W    = 11;

  function automatic int bt_hs(int f_ce);
    return f_ce / 100_000;
  endfunction

  function automatic int bt_ls(int f_ce);
    return f_ce / 12_500;
  endfunction

  localparam int BT_HS = bt_hs(F_CE_DEF);
  localparam int BT_LS = bt_ls(F_CE_DEF);

  function automatic logic pw_legal(logic [TMR_W-1:0] pw, int bt);
    int w;
    w = int'(pw);
    return (w >= bt / 4) && (w <= (3 * bt) / 4);
  endfunction

endpackage

// File: rtl/ar_rx_word_if.sv
// rtl/ar_rx_word_if.sv - received-word read port (FWFT head word plus pop strobe)
interface ar_rx_word_if;
  logic [31:0] dout;
  logic        dout_perr;
  logic        dout_valid;
  logic        rd;

  modport master (output dout, output dout_perr, output dout_valid, input rd);
  modport slave  (input dout, input dout_perr, input dout_valid, output rd);
endinterface

// File: rtl/ar_rx_fifo.sv
// rtl/ar_rx_fifo.sv - DEPTH x 33 first-word-fall-through FIFO with occupancy and overflow pulse
module ar_rx_fifo
  import ar_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push_i,
  input  logic [REC_W-1:0]         din_i,
  input  logic                     pop_i,
  output logic [REC_W-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;
  logic             pop, wr;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = pop_i && !empty_o;
  // a pop in the same clock frees the slot, so a push into a full FIFO still lands
  assign wr      = push_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr)  wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr && pop) cnt_q <= cnt_q - 1'b1;
      ovf_q <= push_i && full_o && !pop;
    end
  end

  assign dout_o = empty_o ? '0 : mem[rd_q];
  assign cnt_o  = cnt_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/ar_rx_word.sv
// rtl/ar_rx_word.sv - ARINC-429 receive front end: slicer, pulse timers, word FSM, word FIFO
// ADC_AVG_EN: 2-tap average of ADC samples ahead of the slicer (one extra ce of latency)
module ar_rx_word
  import ar_rx_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int F_CE  = F_CE_DEF,
  parameter int THR   = 256,
  parameter int HYS   = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    ce,
  input  logic [ADC_W-1:0]        adc_dat,
  input  logic                    hs,
  output logic                    rxp,
  output logic                    rxn,
  ar_rx_word_if.master            rx,
  output logic                    err_width,
  output logic                    err_short,
  output logic                    ovf,
  output logic [7:0]              n_words,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);

  localparam int BT_H = bt_hs(F_CE);
  localparam int BT_L = bt_ls(F_CE);
  localparam logic signed [ADC_W:0] MID   = {2'b01, {(ADC_W-1){1'b0}}};
  localparam logic signed [ADC_W:0] P_SET = (ADC_W+1)'(THR);
  localparam logic signed [ADC_W:0] P_CLR = (ADC_W+1)'(THR - HYS);
  localparam logic signed [ADC_W:0] N_SET = (ADC_W+1)'(-THR);
  localparam logic signed [ADC_W:0] N_CLR = (ADC_W+1)'(-(THR - HYS));

  logic [ADC_W-1:0]        slc_in;
  logic signed [ADC_W:0]   x;
  logic                    rxp_q, rxn_q, rxp_d, rxn_d, pol_q, line;
  logic [TMR_W-1:0]        pw_q, nt_q, gap_thr;
  logic                    fall, gap, legal;
  int                      bt_cur;

  state_e                  state_q, state_d;
  logic [4:0]              bitcnt_q, bitcnt_d;
  logic [31:0]             word_q, word_d, word_nx;
  logic                    hs_q, hs_d;
  logic [7:0]              n_words_q, n_words_d;
  logic                    ew_d, es_d, err_width_q, err_short_q, push;
  logic [REC_W-1:0]        push_rec, head;
  logic                    f_empty, f_full;

`ifdef ADC_AVG_EN
  logic [ADC_W-1:0] prev_q, avg_q;
  logic [ADC_W:0]   sum;

  assign sum = {1'b0, adc_dat} + {1'b0, prev_q};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      prev_q <= MID[ADC_W-1:0];
      avg_q  <= MID[ADC_W-1:0];
    end else if (ce) begin
      prev_q <= adc_dat;
      avg_q  <= sum[ADC_W:1];
    end
  end

  assign slc_in = avg_q;
`else
  assign slc_in = adc_dat;
`endif

  assign x = $signed({1'b0, slc_in}) - MID;

  always_comb begin
    rxp_d = rxp_q ? !(x < P_CLR) : (x > P_SET);
    rxn_d = rxn_q ? !(x > N_CLR) : (x < N_SET);
  end

  assign line    = rxp_q | rxn_q;
  assign bt_cur  = hs_q ? BT_H : BT_L;
  assign gap_thr = hs_q ? TMR_W'(2 * BT_H) : TMR_W'(2 * BT_L);
  // pw_q still holds the finished pulse length on the first low tick
  assign fall    = !line && (pw_q != '0);
  assign gap     = !line && (nt_q == gap_thr);
  assign legal   = pw_legal(pw_q, bt_cur);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rxp_q <= 1'b0;
      rxn_q <= 1'b0;
      pol_q <= 1'b0;
      pw_q  <= '0;
      nt_q  <= '0;
    end else if (ce) begin
      if (!(rxp_d && rxn_d)) begin
        rxp_q <= rxp_d;
        rxn_q <= rxn_d;
      end
      if (line) begin
        pw_q  <= (pw_q == '1) ? pw_q : pw_q + 1'b1;
        nt_q  <= '0;
        pol_q <= rxp_q;
      end else begin
        nt_q  <= (nt_q == '1) ? nt_q : nt_q + 1'b1;
        pw_q  <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    word_d    = word_q;
    hs_d      = hs_q;
    n_words_d = n_words_q;
    ew_d      = 1'b0;
    es_d      = 1'b0;
    push      = 1'b0;
    word_nx   = word_q | (32'(pol_q) << bitcnt_q);
    if (ce) begin
      case (state_q)
        S_SKIP: begin
          if (gap) begin
            state_d  = S_GAP;
            hs_d     = hs;
            bitcnt_d = '0;
          end
        end
        S_GAP: begin
          if (gap) begin
            hs_d = hs;
          end else if (fall) begin
            if (legal) begin
              word_d   = {31'b0, pol_q};
              bitcnt_d = 5'd1;
              state_d  = S_BITS;
            end else begin
              ew_d    = 1'b1;
              state_d = S_SKIP;
            end
          end
        end
        S_BITS: begin
          if (gap) begin
            es_d     = 1'b1;
            state_d  = S_GAP;
            hs_d     = hs;
            bitcnt_d = '0;
          end else if (fall) begin
            if (!legal) begin
              ew_d    = 1'b1;
              state_d = S_SKIP;
            end else if (bitcnt_q == 5'd31) begin
              push      = 1'b1;
              n_words_d = n_words_q + 1'b1;
              word_d    = word_nx;
              state_d   = S_GAP;
              hs_d      = hs;
              bitcnt_d  = '0;
            end else begin
              word_d   = word_nx;
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_SKIP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= S_SKIP;
      bitcnt_q    <= '0;
      word_q      <= '0;
      hs_q        <= 1'b0;
      n_words_q   <= '0;
      err_width_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      word_q      <= word_d;
      hs_q        <= hs_d;
      n_words_q   <= n_words_d;
      err_width_q <= ew_d;
      err_short_q <= es_d;
    end
  end

  // odd parity over all 32 bits: an even count of ones flags an error
  assign push_rec = {~^word_nx, word_nx};

  ar_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .res_n   (res_n),
    .push_i  (push),
    .din_i   (push_rec),
    .pop_i   (rx.rd),
    .dout_o  (head),
    .empty_o (f_empty),
    .full_o  (f_full),
    .cnt_o   (fifo_cnt),
    .ovf_o   (ovf)
  );

  assign rx.dout       = head[31:0];
  assign rx.dout_perr  = head[32];
  assign rx.dout_valid = !f_empty;
  assign rxp           = rxp_q;
  assign rxn           = rxn_q;
  assign err_width     = err_width_q;
  assign err_short     = err_short_q;
  assign n_words       = n_words_q;

endmodule

// File: tb/tb_ar_rx_word.sv
// tb/tb_ar_rx_word.sv - scoreboard bench for ar_rx_word with directed line stimulus
module tb_ar_rx_word;

  localparam int MID = 2048;
  localparam int THR = 256;
  localparam int HYS = 32;
  localparam int HI  = MID + 1000;
  localparam int LO  = MID - 1000;

  logic        clk = 1'b0;
  logic        res_n, ce, hs;
  logic [11:0] adc_dat;
  logic        rxp, rxn, err_width, err_short, ovf;
  logic [7:0]  n_words;
  logic [2:0]  fifo_cnt;

  ar_rx_word_if rx ();

  ar_rx_word #(
    .ADC_W (12),
    .F_CE  (10_000_000),
    .THR   (THR),
    .HYS   (HYS),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .ce        (ce),
    .adc_dat   (adc_dat),
    .hs        (hs),
    .rxp       (rxp),
    .rxn       (rxn),
    .rx        (rx),
    .err_width (err_width),
    .err_short (err_short),
    .ovf       (ovf),
    .n_words   (n_words),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nfail = 0;
  int          n_ew = 0, n_es = 0, n_ov = 0;
  logic [32:0] exp_q [$];
  logic [32:0] e;
  bit          drain_en = 1'b0;
  bit          poke_rd = 1'b0;
  logic        rd_m;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    rd_m = poke_rd;
    if (res_n === 1'b1) begin
      if (err_width) n_ew++;
      if (err_short) n_es++;
      if (ovf)       n_ov++;
    end
    if (drain_en && rx.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_word: got %0h want none", rx.dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 64'(rx.dout), 64'(e[31:0]));
        chk("dout_perr", 64'(rx.dout_perr), 64'(e[32]));
      end
      rd_m = 1'b1;
    end
    rx.rd = rd_m;
  end

  task automatic hold(int lvl, int n);
    adc_dat = 12'(lvl);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(logic [31:0] w, int nb, int bt);
    for (int i = 0; i < nb; i++) begin
      hold(w[i] ? HI : LO, bt / 2);
      hold(MID, bt / 2);
    end
  endtask

  task automatic send_word(logic [31:0] w, int bt, logic perr, bit expect_it);
    if (expect_it) exp_q.push_back({perr, w});
    send_bits(w, 32, bt);
  endtask

  logic [31:0] wv [5];
  logic        pv [5];

  initial begin
    wv[0] = 32'h0000_0001; pv[0] = 1'b0;
    wv[1] = 32'h0000_0003; pv[1] = 1'b1;
    wv[2] = 32'h0000_0007; pv[2] = 1'b0;
    wv[3] = 32'hF000_000F; pv[3] = 1'b1;
    wv[4] = 32'h8000_0000; pv[4] = 1'b0;

    res_n = 1'b0; ce = 1'b1; hs = 1'b1; adc_dat = 12'(MID);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rxp", 64'(rxp), 0);
    chk("rst_rxn", 64'(rxn), 0);
    chk("rst_valid", 64'(rx.dout_valid), 0);
    chk("rst_dout", 64'(rx.dout), 0);
    chk("rst_nwords", 64'(n_words), 0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 0);
    chk("rst_errs", 64'({err_width, err_short, ovf}), 0);
    @(posedge clk); #1;
    res_n = 1'b1;

    // word 1 at 100k, held in the FIFO to inspect the head
    hold(MID, 2000);
    send_word(32'h0000_0001, 100, 1'b0, 1'b1);
    hold(MID, 10);
    chk("w1_valid", 64'(rx.dout_valid), 1);
    chk("w1_fifo_cnt", 64'(fifo_cnt), 1);
    chk("w1_nwords", 64'(n_words), 1);
    drain_en = 1'b1;
    hold(MID, 5);

    // word 2 at 12.5k, even parity
    hs = 1'b0;
    hold(MID, 1700);
    send_word(32'h0000_0003, 800, 1'b1, 1'b1);
    hold(MID, 10);
    chk("w2_nwords", 64'(n_words), 2);
    chk("w2_no_errs", 64'(n_ew + n_es), 0);
    chk("w2_fifo_cnt", 64'(fifo_cnt), 0);

    // narrow pulse mid-word, then a clean word
    hs = 1'b1;
    hold(MID, 1700);
    send_bits(32'h0000_0015, 5, 100);
    hold(HI, 10);
    hold(MID, 490);
    chk("width_err", 64'(n_ew), 1);
    send_word(32'hA5A5_0F0F, 100, 1'b1, 1'b1);
    hold(MID, 10);
    chk("w3_nwords", 64'(n_words), 3);
    chk("w3_width_err", 64'(n_ew), 1);

    // short word terminated by a gap
    send_bits(32'h000F_FFFF, 20, 100);
    hold(MID, 250);
    chk("short_err", 64'(n_es), 1);
    chk("short_nwords", 64'(n_words), 3);
    chk("short_fifo_cnt", 64'(fifo_cnt), 0);

    // five words into a four-deep FIFO
    hold(MID, 400);
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word(wv[i], 100, pv[i], i < 4);
      hold(MID, 400);
    end
    chk("full_fifo_cnt", 64'(fifo_cnt), 4);
    chk("full_ovf", 64'(n_ov), 1);
    chk("full_nwords", 64'(n_words), 8);
    chk("full_head", 64'(rx.dout), 64'h1);
    drain_en = 1'b1;
    hold(MID, 10);
    chk("drain_fifo_cnt", 64'(fifo_cnt), 0);
    chk("drain_sb_empty", 64'(exp_q.size()), 0);
    drain_en = 1'b0;
    poke_rd = 1'b1;
    hold(MID, 3);
    poke_rd = 1'b0;
    chk("rd_empty_cnt", 64'(fifo_cnt), 0);
    chk("rd_empty_valid", 64'(rx.dout_valid), 0);
    chk("rd_empty_ovf", 64'(n_ov), 1);

    // slicer thresholds and hysteresis
    hold(MID, 50);
    hold(MID + THR, 3);
    chk("slc_at_thr", 64'(rxp), 0);
    hold(MID + THR + 1, 1);
    chk("slc_set_lat1", 64'(rxp), 1);
    hold(MID + THR - HYS + 1, 3);
    chk("slc_hys_hold", 64'(rxp), 1);
    hold(MID + THR - HYS, 3);
    chk("slc_hys_edge", 64'(rxp), 1);
    hold(MID + THR - HYS - 1, 3);
    chk("slc_clr", 64'(rxp), 0);
    hold(MID - THR - 1, 3);
    chk("slc_n_set", 64'({rxp, rxn}), 64'b01);
    hold(MID - THR + HYS, 3);
    chk("slc_n_hold", 64'(rxn), 1);
    hold(MID - THR + HYS + 1, 3);
    chk("slc_n_clr", 64'(rxn), 0);
    hold(MID + 300, 3);
    chk("slc_p_again", 64'({rxp, rxn}), 64'b10);
    hold(MID - 300, 3);
    chk("slc_swap", 64'({rxp, rxn}), 64'b01);
    hold(MID, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
